change_dispense_ctrl: RTL and testbench
=======================================

Name: change_dispense_ctrl

Overview:
Sequential transaction controller for the change-making datapath. It latches a Cost/Paid pair on start and owns the coin inventory registers. It plans up to two change coins with greedy 5/3/1 priority against current stock, then hands the coins to a physical dispenser one at a time over a valid/ready handshake. Inventory is debited per accepted coin; status flags are reported with a one-cycle done pulse.

Parameters:
MAX_COINS, 2, maximum coins dispensed per transaction (fixed at 2; present for documentation only)
INV_W, 2, width of each inventory counter (capacity 0..3)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin transaction; accepted only in IDLE
cost  in  4  item cost, sampled on accepted start
paid  in  4  amount paid, sampled on accepted start
load_inv  in  1  restock strobe; accepted only in IDLE
load_p  in  2  pentagon (5) count to load
load_t  in  2  triangle (3) count to load
load_c  in  2  circle (1) count to load
disp_ready  in  1  dispenser accepts disp_coin this cycle
disp_valid  out  1  disp_coin is valid
disp_coin  out  3  coin value 0/1/3/5
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of transaction
exact_amount  out  1  paid == cost and paid != 0
cough_up_more  out  1  paid < cost
not_enough_change  out  1  change owed but remaining != 0 after dispense
remaining  out  4  change still owed after dispense (0 when cough_up_more)
inv_p, inv_t, inv_c  out  2 each  current inventory

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs, flags, latched cost/paid, plan registers and inventory = 0.
- States: IDLE, EVAL, COIN1, COIN2, DONE.
- IDLE: load_inv=1 loads inv_* from load_* next edge; load_inv wins over start in the same cycle (start dropped, busy stays 0). Else start=1 latches cost/paid, clears all status flags and remaining, goes to EVAL.
- EVAL (one cycle): change = paid - cost (4-bit, used only when paid > cost).
  - paid < cost: cough_up_more=1, remaining=0 -> DONE.
  - paid == cost: exact_amount = (paid != 0), remaining=0 -> DONE.
  - paid > cost: coin_planner picks coin1 from change and stock, then coin2 from (change - coin1) and stock minus coin1. Pick rule per coin: 5 if rem>=5 and stock>0, else 3 if rem>=3 and stock>0, else 1 if rem>=1 and stock>0, else 0. Register coin1, coin2, remaining = change - coin1 - coin2; not_enough_change = (remaining != 0). Go to COIN1 if coin1 != 0, else DONE.
- COIN1: disp_valid=1, disp_coin=coin1, held stable until disp_ready=1. On the handshake edge, debit the matching inventory counter by 1, then go to COIN2 if coin2 != 0, else DONE.
- COIN2: same handshake as COIN1 with coin2; then DONE.
- disp_ready while disp_valid=0 is ignored. disp_valid never drops without a handshake except on reset.
- DONE: done=1 for exactly one cycle -> IDLE. Flags and remaining hold until the next accepted start.
- start and load_inv while busy: ignored, no effect.
- Inventory never underflows; the planner guarantees stock > 0 for each chosen coin.
- Latency: start accepted at edge t; EVAL in cycle t+1; disp_valid from cycle t+2 (no-change cases: done in cycle t+2). Minimum two-coin transaction with ready held high: done in cycle t+4.
- Reset mid-transaction: abort immediately. No debit for an un-handshaken coin, and inventory clears to 0.

Decomposition:
- Package change_pkg holds:
  - coin_t enum: NONE=0, CIRCLE=1, TRIANGLE=3, PENTAGON=5 (3-bit)
  - state_t enum for the five states
  - INV_W and MAX_COINS
- Sub-module coin_planner (combinational): change and inventory in; coin1, coin2, remaining out.

Test Plan:
- Load P=1,T=1,C=2; start cost=3 paid=12 -> coins 5 then 3, remaining=1, not_enough_change=1, inv becomes P=0,T=0,C=2, done one cycle after second handshake.
- start cost=7 paid=7 -> exact_amount=1, disp_valid never asserts, done in cycle t+2; repeat with cost=0 paid=0 -> exact_amount=0, done still pulses.
- start cost=9 paid=4 -> cough_up_more=1, remaining=0, inventory unchanged.
- P=1,C=1; cost=2 paid=8 (change 6) with disp_ready low 3 cycles -> disp_coin=5 stable with disp_valid high throughout, then coin 1, remaining=0, inv P=0,C=0.
- In IDLE assert load_inv=1 with load_p=3 and start=1 together -> inv_p=3, busy stays 0; start=1 while busy -> ignored.
- Drop reset_n while in COIN2 -> same cycle: disp_valid=0, busy=0, inv_*=0, all flags 0.

Source files
------------

// File: rtl/change_dispense_ctrl_pkg.sv
// Shared types and helpers for the change dispense controller: coin encoding,
// FSM states, inventory record and the greedy single-coin pick rule.
package change_pkg;
  localparam int MAX_COINS = 2;
  localparam int INV_W     = 2;

  typedef enum logic [2:0] {
    NONE     = 3'd0,
    CIRCLE   = 3'd1,
    TRIANGLE = 3'd3,
    PENTAGON = 3'd5
  } coin_t;

  typedef enum logic [2:0] {IDLE, EVAL, COIN1, COIN2, DONE} state_t;

  typedef struct packed {
    logic [INV_W-1:0] p;
    logic [INV_W-1:0] t;
    logic [INV_W-1:0] c;
  } inv_t;

  localparam logic [INV_W-1:0] INV_ONE = 1;

  // Largest coin that fits the amount still owed and is actually in stock.
  function automatic coin_t pick(input logic [3:0] rem, input inv_t s);
    if (rem >= 4'd5 && s.p != '0)      return PENTAGON;
    else if (rem >= 4'd3 && s.t != '0) return TRIANGLE;
    else if (rem >= 4'd1 && s.c != '0) return CIRCLE;
    else                               return NONE;
  endfunction

  function automatic inv_t debit(input inv_t s, input coin_t coin);
    inv_t r;
    r = s;
    case (coin)
      PENTAGON: r.p = s.p - INV_ONE;
      TRIANGLE: r.t = s.t - INV_ONE;
      CIRCLE:   r.c = s.c - INV_ONE;
      default:  r = s;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Transaction, restock, dispenser handshake and status bundle of the controller.
interface change_dispense_ctrl_if;
  import change_pkg::*;

  logic             start;
  logic [3:0]       cost;
  logic [3:0]       paid;
  logic             load_inv;
  logic [INV_W-1:0] load_p, load_t, load_c;
  logic             disp_ready;
  logic             disp_valid;
  coin_t            disp_coin;
  logic             busy;
  logic             done;
  logic             exact_amount;
  logic             cough_up_more;
  logic             not_enough_change;
  logic [3:0]       remaining;
  logic [INV_W-1:0] inv_p, inv_t, inv_c;

  modport master (
    output start, cost, paid, load_inv, load_p, load_t, load_c, disp_ready,
    input  disp_valid, disp_coin, busy, done, exact_amount, cough_up_more,
           not_enough_change, remaining, inv_p, inv_t, inv_c
  );

  modport slave (
    input  start, cost, paid, load_inv, load_p, load_t, load_c, disp_ready,
    output disp_valid, disp_coin, busy, done, exact_amount, cough_up_more,
           not_enough_change, remaining, inv_p, inv_t, inv_c
  );
endinterface

// File: rtl/change_dispense_ctrl_planner.sv
// Two-coin greedy change plan against current stock; the second pick sees
// the stock already reduced by the first coin.
module coin_planner
  import change_pkg::*;
(
  input  logic [3:0] change,
  input  inv_t       stock,
  output coin_t      coin1,
  output coin_t      coin2,
  output logic [3:0] remaining
);
  logic [3:0] rem1;
  inv_t       stock2;

  always_comb begin
    coin1     = pick(change, stock);
    rem1      = change - 4'(coin1);
    stock2    = debit(stock, coin1);
    coin2     = pick(rem1, stock2);
    remaining = rem1 - 4'(coin2);
  end
endmodule

// File: rtl/change_dispense_ctrl.sv
// Change dispense transaction FSM: latch cost/paid, plan coins, hand them to
// the dispenser over valid/ready, debit inventory per accepted coin.
module change_dispense_ctrl
  import change_pkg::*;
(
  input logic                   clock,
  input logic                   reset_n,
  change_dispense_ctrl_if.slave bus
);
  state_t     state;
  logic [3:0] cost_q, paid_q;
  coin_t      plan2;
  inv_t       inv;

  logic [3:0] change;
  coin_t      c1, c2;
  logic [3:0] rem;

  assign change = paid_q - cost_q;

  coin_planner u_planner (
    .change    (change),
    .stock     (inv),
    .coin1     (c1),
    .coin2     (c2),
    .remaining (rem)
  );

  assign bus.inv_p = inv.p;
  assign bus.inv_t = inv.t;
  assign bus.inv_c = inv.c;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                 <= IDLE;
      cost_q                <= '0;
      paid_q                <= '0;
      plan2                 <= NONE;
      inv                   <= '0;
      bus.disp_valid        <= 1'b0;
      bus.disp_coin         <= NONE;
      bus.busy              <= 1'b0;
      bus.done              <= 1'b0;
      bus.exact_amount      <= 1'b0;
      bus.cough_up_more     <= 1'b0;
      bus.not_enough_change <= 1'b0;
      bus.remaining         <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          // Restock takes priority; a coincident start is dropped.
          if (bus.load_inv) begin
            inv <= '{p: bus.load_p, t: bus.load_t, c: bus.load_c};
          end else if (bus.start) begin
            cost_q                <= bus.cost;
            paid_q                <= bus.paid;
            bus.exact_amount      <= 1'b0;
            bus.cough_up_more     <= 1'b0;
            bus.not_enough_change <= 1'b0;
            bus.remaining         <= '0;
            bus.busy              <= 1'b1;
            state                 <= EVAL;
          end
        end
        EVAL: begin
          if (paid_q < cost_q) begin
            bus.cough_up_more <= 1'b1;
            bus.done          <= 1'b1;
            state             <= DONE;
          end else if (paid_q == cost_q) begin
            bus.exact_amount <= (paid_q != '0);
            bus.done         <= 1'b1;
            state            <= DONE;
          end else begin
            plan2                 <= c2;
            bus.remaining         <= rem;
            bus.not_enough_change <= (rem != '0);
            if (c1 != NONE) begin
              bus.disp_valid <= 1'b1;
              bus.disp_coin  <= c1;
              state          <= COIN1;
            end else begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        COIN1: begin
          if (bus.disp_ready) begin
            inv <= debit(inv, bus.disp_coin);
            if (plan2 != NONE) begin
              bus.disp_coin <= plan2;
              state         <= COIN2;
            end else begin
              bus.disp_valid <= 1'b0;
              bus.disp_coin  <= NONE;
              bus.done       <= 1'b1;
              state          <= DONE;
            end
          end
        end
        COIN2: begin
          if (bus.disp_ready) begin
            inv            <= debit(inv, bus.disp_coin);
            bus.disp_valid <= 1'b0;
            bus.disp_coin  <= NONE;
            bus.done       <= 1'b1;
            state          <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Randomized bench for change_dispense_ctrl against a greedy change model.
module tb_change_dispense_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   mp = 0, mt = 0, mc = 0;

  change_dispense_ctrl_if bus ();

  change_dispense_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_valid"}, bus.disp_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_flags"}, {bus.exact_amount, bus.cough_up_more, bus.not_enough_change}, 0);
    chk({tag, "_rem"}, bus.remaining, 0);
    chk({tag, "_inv"}, {bus.inv_p, bus.inv_t, bus.inv_c}, 0);
  endtask

  task automatic load(input int p, input int t, input int c);
    @(negedge clock);
    bus.load_inv = 1'b1;
    bus.load_p = 2'(p); bus.load_t = 2'(t); bus.load_c = 2'(c);
    @(negedge clock);
    bus.load_inv = 1'b0;
    mp = p; mt = t; mc = c;
    chk("load_inv", {bus.inv_p, bus.inv_t, bus.inv_c}, {2'(p), 2'(t), 2'(c)});
  endtask

  // One full transaction; ready is random with pct chance, forced low for the
  // first hold cycles that a coin is offered.
  task automatic txn(input int cost, input int paid, input int pct, input int hold);
    int exp_coins[$];
    int got[$];
    int rem, sp, st, sc, exp_rem;
    int k, done_k, first_v, last_hs, pc, exp_done;
    bit pv, phs, rdy;
    sp = mp; st = mt; sc = mc; rem = 0;
    if (paid > cost) begin
      rem = paid - cost;
      repeat (2) begin
        if (rem >= 5 && sp > 0)      begin exp_coins.push_back(5); rem -= 5; sp--; end
        else if (rem >= 3 && st > 0) begin exp_coins.push_back(3); rem -= 3; st--; end
        else if (rem >= 1 && sc > 0) begin exp_coins.push_back(1); rem -= 1; sc--; end
      end
    end
    exp_rem = rem;

    @(negedge clock);
    bus.start = 1'b1; bus.cost = 4'(cost); bus.paid = 4'(paid);
    @(negedge clock);
    bus.start = 1'b0;
    chk("busy_eval", bus.busy, 1);
    chk("valid_eval", bus.disp_valid, 0);
    k = 1; done_k = -1; first_v = -1; last_hs = -1; pv = 0; phs = 0; pc = 0;
    while (k < 60) begin
      @(negedge clock);
      k++;
      if (bus.done) begin done_k = k; break; end
      if (pv && !phs) begin
        chk("valid_hold", bus.disp_valid, 1);
        chk("coin_hold", int'(bus.disp_coin), pc);
      end
      if (bus.disp_valid && first_v < 0) first_v = k;
      rdy = (hold > 0 && bus.disp_valid) ? 1'b0 : ($urandom_range(99) < pct);
      if (bus.disp_valid && hold > 0) hold--;
      bus.disp_ready = rdy;
      bus.start    = ($urandom_range(3) == 0);
      bus.load_inv = ($urandom_range(3) == 0);
      bus.load_p = 2'($urandom_range(3)); bus.load_t = 2'($urandom_range(3));
      bus.load_c = 2'($urandom_range(3));
      bus.cost = 4'($urandom_range(15)); bus.paid = 4'($urandom_range(15));
      pv = bus.disp_valid; pc = int'(bus.disp_coin); phs = pv && rdy;
      if (phs) begin got.push_back(pc); last_hs = k; end
    end
    bus.start = 1'b0; bus.load_inv = 1'b0; bus.disp_ready = 1'b0;

    chk("done_seen", int'(done_k >= 0), 1);
    exp_done = (exp_coins.size() == 0) ? 2 : last_hs + 1;
    chk("done_cycle", done_k, exp_done);
    chk("first_valid", first_v, (exp_coins.size() == 0) ? -1 : 2);
    chk("coin_count", got.size(), exp_coins.size());
    for (int i = 0; i < got.size() && i < exp_coins.size(); i++)
      chk($sformatf("coin%0d", i + 1), got[i], exp_coins[i]);
    chk("busy_done", bus.busy, 1);
    chk("exact", bus.exact_amount, int'(paid == cost && paid != 0));
    chk("cough", bus.cough_up_more, int'(paid < cost));
    chk("nec", bus.not_enough_change, int'(exp_rem != 0));
    chk("remaining", bus.remaining, exp_rem);
    chk("inv_p", bus.inv_p, sp);
    chk("inv_t", bus.inv_t, st);
    chk("inv_c", bus.inv_c, sc);
    mp = sp; mt = st; mc = sc;
    @(negedge clock);
    chk("done_pulse", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("rem_hold", bus.remaining, exp_rem);
  endtask

  initial begin
    bus.start = 0; bus.cost = 0; bus.paid = 0; bus.load_inv = 0;
    bus.load_p = 0; bus.load_t = 0; bus.load_c = 0; bus.disp_ready = 0;
    #12;
    chk_idle_zero("reset");
    @(negedge clock);
    reset_n = 1'b1;

    load(1, 1, 2);
    txn(3, 12, 100, 0);
    txn(7, 7, 100, 0);
    txn(0, 0, 100, 0);
    txn(9, 4, 100, 0);
    load(1, 0, 1);
    txn(2, 8, 100, 3);

    // Restock and start together: restock wins, start is dropped.
    @(negedge clock);
    bus.load_inv = 1'b1; bus.load_p = 2'd3; bus.load_t = 2'd0; bus.load_c = 2'd0;
    bus.start = 1'b1; bus.cost = 4'd0; bus.paid = 4'd5;
    @(negedge clock);
    bus.load_inv = 1'b0; bus.start = 1'b0;
    mp = 3; mt = 0; mc = 0;
    chk("ld_start_inv_p", bus.inv_p, 3);
    chk("ld_start_busy", bus.busy, 0);
    @(negedge clock);
    chk("ld_start_busy2", bus.busy, 0);

    // Reset while the second coin is on offer.
    load(1, 1, 0);
    @(negedge clock);
    bus.start = 1'b1; bus.cost = 4'd0; bus.paid = 4'd9;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    chk("rst_c1_coin", int'(bus.disp_coin), 5);
    bus.disp_ready = 1'b1;
    @(negedge clock);
    bus.disp_ready = 1'b0;
    chk("rst_c2_coin", int'(bus.disp_coin), 3);
    chk("rst_c2_inv_p", bus.inv_p, 0);
    chk("rst_c2_nec", bus.not_enough_change, 1);
    #2 reset_n = 1'b0;
    #1 chk_idle_zero("midrst");
    @(negedge clock);
    reset_n = 1'b1;
    mp = 0; mt = 0; mc = 0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1) == 0)
        load($urandom_range(3), $urandom_range(3), $urandom_range(3));
      txn($urandom_range(15), $urandom_range(15), $urandom_range(30, 100), $urandom_range(2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
